// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle MIPS-style datapath: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath enable and mux select.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PC_En,
  output logic       I_or_D,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       ALU_Src_A,
  output logic [1:0] Reg_Dst,
  output logic [1:0] Mem_to_Reg,
  output logic [1:0] ALU_Src_B,
  output logic [1:0] PC_Src,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALU_Control,
  output logic [3:0] State_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    IMMEX    = 4'd9,
    IMMWB    = 4'd10,
    JUMP     = 4'd11,
    GPIOWB   = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  state_t     next_state;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic [2:0] imm_alu;
  logic [1:0] imm_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // R-type ALU decode; funct_ok gates the write-back so unknown functs are dropped
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b101010:            funct_alu = ALU_SLT;
      default:              funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu = ALU_ADD;
    imm_sel = 2'b00;
    case (Op)
      6'b001010: imm_alu = ALU_SLT;
      6'b001100: begin imm_alu = ALU_AND; imm_sel = 2'b01; end
      6'b001101: begin imm_alu = ALU_OR;  imm_sel = 2'b01; end
      6'b001111: imm_sel = 2'b10;
      default:   ;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (Op)
          6'b100011, 6'b101011:                         next_state = MEMADR;
          6'b000000:                                    next_state = EXECUTE;
          6'b000100, 6'b000101:                         next_state = BRANCH;
          6'b001000, 6'b001010, 6'b001100,
          6'b001101, 6'b001111:                         next_state = IMMEX;
          6'b000010, 6'b000011:                         next_state = JUMP;
          6'b111111:                                    next_state = GPIOWB;
          default:                                      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (Op == 6'b101011) ? MEMWRITE : MEMREAD;
      MEMREAD: next_state = MEMWB;
      EXECUTE: next_state = funct_ok ? ALUWB : FETCH;
      IMMEX:   next_state = IMMWB;
      default: next_state = FETCH;
    endcase
  end

  // Reset suppresses every strobe at once so an aborted instruction writes nothing
  always_comb begin
    PC_En       = 1'b0;
    I_or_D      = 1'b0;
    Mem_Write   = 1'b0;
    IR_Write    = 1'b0;
    Reg_Write   = 1'b0;
    ALU_Src_A   = 1'b0;
    Reg_Dst     = 2'b00;
    Mem_to_Reg  = 2'b00;
    ALU_Src_B   = 2'b00;
    PC_Src      = 2'b00;
    ImmSrc      = 2'b00;
    ALU_Control = 3'b000;
    case (state)
      FETCH: begin
        IR_Write = 1'b1; ALU_Src_B = 2'd1; ALU_Control = ALU_ADD; PC_En = 1'b1;
      end
      DECODE: begin
        ALU_Src_B = 2'd3; ALU_Control = ALU_ADD;
        if (Op == 6'b000011) begin
          Reg_Write = 1'b1; Reg_Dst = 2'd2;
        end
      end
      MEMADR: begin
        ALU_Src_A = 1'b1; ALU_Src_B = 2'd2; ALU_Control = ALU_ADD;
      end
      MEMREAD:  I_or_D = 1'b1;
      MEMWB:    begin Mem_to_Reg = 2'd1; Reg_Write = 1'b1; end
      MEMWRITE: begin I_or_D = 1'b1; Mem_Write = 1'b1; end
      EXECUTE:  begin ALU_Src_A = 1'b1; ALU_Control = funct_alu; end
      ALUWB:    begin Reg_Dst = 2'd1; Reg_Write = 1'b1; end
      BRANCH: begin
        ALU_Src_A = 1'b1; ALU_Control = ALU_SUB; PC_Src = 2'd1;
        PC_En = ((Op == 6'b000100) && Zero) || ((Op == 6'b000101) && !Zero);
      end
      IMMEX: begin
        ALU_Src_A = 1'b1; ALU_Src_B = 2'd2; ALU_Control = imm_alu; ImmSrc = imm_sel;
      end
      IMMWB:   Reg_Write = 1'b1;
      JUMP:    begin PC_Src = 2'd2; PC_En = 1'b1; end
      GPIOWB:  begin Mem_to_Reg = 2'd2; Reg_Write = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      PC_En     = 1'b0;
      IR_Write  = 1'b0;
      Mem_Write = 1'b0;
      Reg_Write = 1'b0;
    end
  end

  assign State_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed test-plan cases plus randomized
// instructions, every cycle checked against a per-instruction path/output model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A;
  logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src, ImmSrc;
  logic [2:0] ALU_Control;
  logic [3:0] State_o;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, imm_src;
    logic [2:0] alu_ctl;
  } outs_t;

  outs_t      act;
  int         checks = 0;
  int         failures = 0;
  int         path[$];
  outs_t      trace[$];
  logic [2:0] funct_alu [64];
  bit         funct_ok [64];
  logic [4:0] imm_tab [64];
  logic [5:0] op_pool [16];
  logic [5:0] funct_pool [8];

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PC_En(PC_En), .I_or_D(I_or_D), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A), .Reg_Dst(Reg_Dst),
    .Mem_to_Reg(Mem_to_Reg), .ALU_Src_B(ALU_Src_B), .PC_Src(PC_Src),
    .ImmSrc(ImmSrc), .ALU_Control(ALU_Control), .State_o(State_o)
  );

  assign act = {State_o, PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A,
                Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src, ImmSrc, ALU_Control};

  always #10 clk = ~clk;

  // Sequence of states an instruction visits, starting from its fetch cycle
  function automatic void build_path(logic [5:0] op, logic [5:0] funct);
    path = {};
    path.push_back(0);
    path.push_back(1);
    case (op)
      6'h23: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'h2B: begin path.push_back(2); path.push_back(5); end
      6'h00: begin path.push_back(6); if (funct_ok[funct]) path.push_back(7); end
      6'h04, 6'h05: path.push_back(8);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin path.push_back(9); path.push_back(10); end
      6'h02, 6'h03: path.push_back(11);
      6'h3F: path.push_back(12);
      default: ;
    endcase
  endfunction

  function automatic outs_t expect_outs(int st, logic [5:0] op, logic [5:0] funct,
                                        logic zero, logic rst);
    outs_t e;
    e = '0;
    e.st = rst ? 4'd0 : 4'(st);
    if (rst) st = 0;
    case (st)
      0:  begin e.ir_write = 1; e.alu_src_b = 1; e.alu_ctl = 3'b010; e.pc_en = 1; end
      1:  begin
            e.alu_src_b = 3; e.alu_ctl = 3'b010;
            if (op == 6'h03) begin e.reg_write = 1; e.reg_dst = 2; end
          end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2; e.alu_ctl = 3'b010; end
      3:  e.i_or_d = 1;
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      5:  begin e.i_or_d = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 1; e.alu_ctl = funct_alu[funct]; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; end
      8:  begin
            e.alu_src_a = 1; e.alu_ctl = 3'b110; e.pc_src = 1;
            e.pc_en = (op == 6'h04) ? zero : (op == 6'h05) ? !zero : 1'b0;
          end
      9:  begin
            e.alu_src_a = 1; e.alu_src_b = 2;
            {e.alu_ctl, e.imm_src} = imm_tab[op];
          end
      10: e.reg_write = 1;
      11: begin e.pc_src = 2; e.pc_en = 1; end
      12: begin e.mem_to_reg = 2; e.reg_write = 1; end
      default: ;
    endcase
    if (rst) begin
      e.pc_en = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got st=%0d bits=%h, expected st=%0d bits=%h",
               name, act.st, act, exp.st, exp);
    end
  endtask

  task automatic checkField(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Runs one instruction from its FETCH cycle; zmode 0/1 fixes Zero, 2 randomizes it
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input int zmode, input int abort_idx);
    Op = op;
    Funct = funct;
    build_path(op, funct);
    trace = {};
    foreach (path[i]) begin
      Zero = (zmode == 2) ? ($urandom_range(0, 1) == 1) : (zmode == 1);
      #2;
      checkOutput($sformatf("op%02h_f%02h_st%0d", op, funct, path[i]),
                  expect_outs(path[i], op, funct, Zero, 1'b0));
      trace.push_back(act);
      if (i == abort_idx) begin
        #3 reset = 1'b1;
        #1;
        checkField("abort_state", int'(State_o), 0);
        checkField("abort_strobes", int'({Mem_Write, Reg_Write, PC_En, IR_Write}), 0);
        @(posedge clk); #1;
        checkOutput("abort_hold", expect_outs(0, op, funct, Zero, 1'b1));
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int rw_count;
    logic [5:0] rop, rfunct;
    int abort_idx;

    for (int i = 0; i < 64; i++) begin
      funct_alu[i] = 3'b010; funct_ok[i] = 1'b0; imm_tab[i] = {3'b010, 2'b00};
    end
    funct_alu[6'h20] = 3'b010; funct_ok[6'h20] = 1'b1;
    funct_alu[6'h21] = 3'b010; funct_ok[6'h21] = 1'b1;
    funct_alu[6'h22] = 3'b110; funct_ok[6'h22] = 1'b1;
    funct_alu[6'h23] = 3'b110; funct_ok[6'h23] = 1'b1;
    funct_alu[6'h24] = 3'b000; funct_ok[6'h24] = 1'b1;
    funct_alu[6'h25] = 3'b001; funct_ok[6'h25] = 1'b1;
    funct_alu[6'h2A] = 3'b111; funct_ok[6'h2A] = 1'b1;
    imm_tab[6'h08] = {3'b010, 2'b00};
    imm_tab[6'h0A] = {3'b111, 2'b00};
    imm_tab[6'h0C] = {3'b000, 2'b01};
    imm_tab[6'h0D] = {3'b001, 2'b01};
    imm_tab[6'h0F] = {3'b010, 2'b10};
    op_pool = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                6'h0D, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h00, 6'h23};
    funct_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h07};

    #1 reset = 1'b1;
    #1 checkField("async_reset_state", int'(State_o), 0);
    repeat (3) begin
      @(posedge clk); #2;
      checkOutput("reset_hold", expect_outs(0, Op, Funct, Zero, 1'b1));
      checkField("reset_strobes", int'({PC_En, IR_Write, Mem_Write, Reg_Write}), 0);
    end
    @(posedge clk); #1 reset = 1'b0;

    applyStimulus(6'h23, 6'h00, 2, -1);
    checkField("lw_len", trace.size(), 5);
    checkField("fetch_pc_en", int'(trace[0].pc_en), 1);
    checkField("fetch_ir_write", int'(trace[0].ir_write), 1);
    checkField("decode_ir_write", int'(trace[1].ir_write), 0);
    checkField("lw_memread_iord", int'(trace[3].i_or_d), 1);
    checkField("lw_memwb_regwrite", int'(trace[4].reg_write), 1);
    checkField("lw_memwb_memtoreg", int'(trace[4].mem_to_reg), 1);

    applyStimulus(6'h04, 6'h00, 1, -1);
    checkField("beq_z1_pc_en", int'(trace[2].pc_en), 1);
    checkField("beq_pc_src", int'(trace[2].pc_src), 1);
    applyStimulus(6'h04, 6'h00, 0, -1);
    checkField("beq_z0_pc_en", int'(trace[2].pc_en), 0);
    applyStimulus(6'h05, 6'h00, 0, -1);
    checkField("bne_z0_pc_en", int'(trace[2].pc_en), 1);

    applyStimulus(6'h00, 6'h2A, 2, -1);
    checkField("slt_alu", int'(trace[2].alu_ctl), 7);
    checkField("slt_wb_state", int'(trace[3].st), 7);
    applyStimulus(6'h00, 6'h07, 2, -1);
    checkField("badfunct_len", trace.size(), 3);
    rw_count = 0;
    foreach (trace[i]) rw_count += int'(trace[i].reg_write);
    checkField("badfunct_regwrite", rw_count, 0);

    applyStimulus(6'h03, 6'h00, 2, -1);
    checkField("jal_len", trace.size(), 3);
    checkField("jal_decode_regwrite", int'(trace[1].reg_write), 1);
    checkField("jal_decode_regdst", int'(trace[1].reg_dst), 2);
    checkField("jal_jump_pcsrc", int'(trace[2].pc_src), 2);
    checkField("jal_jump_pc_en", int'(trace[2].pc_en), 1);

    applyStimulus(6'h0D, 6'h00, 2, -1);
    checkField("ori_immsrc", int'(trace[2].imm_src), 1);
    checkField("ori_alu", int'(trace[2].alu_ctl), 1);

    applyStimulus(6'h2B, 6'h00, 2, 3);
    checkField("sw_memwrite_before_abort", int'(trace[3].mem_write), 1);

    applyStimulus(6'h3F, 6'h00, 2, -1);
    checkField("in_state", int'(trace[2].st), 12);
    checkField("in_memtoreg", int'(trace[2].mem_to_reg), 2);

    applyStimulus(6'h01, 6'h00, 2, -1);
    checkField("unsupported_len", trace.size(), 2);

    repeat (300) begin
      rop = ($urandom_range(0, 19) < 16) ? op_pool[$urandom_range(0, 15)] : 6'($urandom);
      rfunct = ($urandom_range(0, 9) < 8) ? funct_pool[$urandom_range(0, 7)] : 6'($urandom);
      abort_idx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(rop, rfunct, 2, abort_idx);
    end

    #2 checkField("final_state", int'(State_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
